alu_frame_intf: RTL and testbench

ALU_FRAME_INTF -- requirements
Module: alu_frame_intf

---
 rtl/alu_frame_intf.sv | 157 +++++++++++++++
 tb/tb_alu_frame_intf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_intf.sv
// UART-to-ALU framing bridge: assembles little-endian operands A and B plus an opcode from RX bytes,
// then streams the ALU result back to the UART TX LSB byte first, with an inter-byte frame timeout.
module alu_frame_intf #(
  parameter int DBIT        = 8,
  parameter int DATA_W      = 16,
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [DBIT-1:0]   i_rx_data,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_tx_done,
  output logic [DATA_W-1:0] o_alu_datoa,
  output logic [DATA_W-1:0] o_alu_datob,
  output logic [OP_W-1:0]   o_alu_opcode,
  output logic [DBIT-1:0]   o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_frame_err
);

  localparam int NB    = DATA_W / DBIT;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_OPA, S_OPB, S_OPCODE, S_EXEC, S_TX_LOAD, S_TX_WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  rx_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] asm_reg;
  logic [DATA_W-1:0] tx_shift;

  logic              rx_state;
  logic              partial;
  logic              timeout;
  logic [DATA_W-1:0] asm_next;
  logic [DATA_W-1:0] tx_next;

  function automatic logic [DATA_W-1:0] insert_byte(input logic [DATA_W-1:0] word,
                                                     input logic [CNT_W-1:0]  idx,
                                                     input logic [DBIT-1:0]   b);
    logic [DATA_W-1:0] w;
    w = word;
    w[int'(idx)*DBIT +: DBIT] = b;
    return w;
  endfunction

  always_comb begin
    rx_state = (state == S_OPA) || (state == S_OPB) || (state == S_OPCODE);
    // Once operand A has started, every receive state belongs to an open frame.
    partial  = ((state == S_OPA) && (rx_cnt != '0)) || (state == S_OPB) || (state == S_OPCODE);
    // A byte landing on the expiry edge wins over the timeout.
    timeout  = TO_EN && partial && !i_rx_done && (to_cnt == TO_LAST);
    asm_next = insert_byte(asm_reg, rx_cnt, i_rx_data);
    tx_next  = tx_shift >> DBIT;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= S_OPA;
      rx_cnt       <= '0;
      tx_cnt       <= '0;
      to_cnt       <= '0;
      asm_reg      <= '0;
      tx_shift     <= '0;
      o_alu_datoa  <= '0;
      o_alu_datob  <= '0;
      o_alu_opcode <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_tx_start  <= 1'b0;
      o_frame_err <= 1'b0;

      if (timeout) begin
        // Drop the partial frame; completed operand/opcode registers are left untouched.
        o_frame_err <= 1'b1;
        rx_cnt      <= '0;
        to_cnt      <= '0;
        state       <= S_OPA;
      end else begin
        if (rx_state && i_rx_done) begin
          to_cnt <= '0;
        end else if (partial) begin
          to_cnt <= to_cnt + 1'b1;
        end else begin
          to_cnt <= '0;
        end

        case (state)
          S_OPA, S_OPB: begin
            if (i_rx_done) begin
              asm_reg <= asm_next;
              if (rx_cnt == LAST_BYTE) begin
                rx_cnt <= '0;
                if (state == S_OPA) begin
                  o_alu_datoa <= asm_next;
                  state       <= S_OPB;
                end else begin
                  o_alu_datob <= asm_next;
                  state       <= S_OPCODE;
                end
              end else begin
                rx_cnt <= rx_cnt + 1'b1;
              end
            end
          end
          S_OPCODE: begin
            if (i_rx_done) begin
              o_alu_opcode <= i_rx_data[OP_W-1:0];
              o_busy       <= 1'b1;
              state        <= S_EXEC;
            end
          end
          S_EXEC: begin
            // Start pulse and first byte are registered so they line up with S_TX_LOAD.
            tx_shift   <= i_alu_result;
            tx_cnt     <= '0;
            o_tx_data  <= i_alu_result[DBIT-1:0];
            o_tx_start <= 1'b1;
            state      <= S_TX_LOAD;
          end
          S_TX_LOAD: begin
            state <= S_TX_WAIT;
          end
          S_TX_WAIT: begin
            if (i_tx_done) begin
              if (tx_cnt == LAST_BYTE) begin
                o_busy <= 1'b0;
                state  <= S_OPA;
              end else begin
                tx_cnt     <= tx_cnt + 1'b1;
                tx_shift   <= tx_next;
                o_tx_data  <= tx_next[DBIT-1:0];
                o_tx_start <= 1'b1;
                state      <= S_TX_LOAD;
              end
            end
          end
          default: state <= S_OPA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_intf.sv
// Self-checking bench for alu_frame_intf: directed and random frames against a frame-level reference model.
module tb_alu_frame_intf;

  localparam int DBIT        = 8;
  localparam int DATA_W      = 16;
  localparam int OP_W        = 6;
  localparam int TIMEOUT_CYC = 1000;
  localparam int NB          = DATA_W / DBIT;

  logic              i_clock = 1'b0;
  logic              i_reset;
  logic              i_rx_done;
  logic [DBIT-1:0]   i_rx_data;
  logic [DATA_W-1:0] i_alu_result;
  logic              i_tx_done;
  logic [DATA_W-1:0] o_alu_datoa;
  logic [DATA_W-1:0] o_alu_datob;
  logic [OP_W-1:0]   o_alu_opcode;
  logic [DBIT-1:0]   o_tx_data;
  logic              o_tx_start;
  logic              o_busy;
  logic              o_frame_err;

  always #5 i_clock = ~i_clock;

  alu_frame_intf #(
    .DBIT(DBIT), .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_alu_result(i_alu_result), .i_tx_done(i_tx_done), .o_alu_datoa(o_alu_datoa),
    .o_alu_datob(o_alu_datob), .o_alu_opcode(o_alu_opcode), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      6'h03:   return a - b;
      6'h04:   return a & b;
      6'h05:   return a | b;
      6'h06:   return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign i_alu_result = alu_f(o_alu_opcode, o_alu_datoa, o_alu_datob);

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int tx_cd = 0;
  int first_start_cyc = -1;
  bit tx_hold = 1'b0;
  logic [DBIT-1:0] tx_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required < 200000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: UART TX responder, edge, then sample outputs 1 time unit later.
  task automatic step();
    if (tx_hold) i_tx_done = 1'b1;
    else if (tx_cd > 0) begin
      tx_cd--;
      i_tx_done = (tx_cd == 0);
    end else i_tx_done = 1'b0;
    @(posedge i_clock);
    #1;
    cyc++;
    if (o_tx_start) begin
      tx_q.push_back(o_tx_data);
      tx_cd = 4;
      if (first_start_cyc < 0) first_start_cyc = cyc;
    end
    if (o_frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  endtask

  task automatic send_byte(input logic [DBIT-1:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    step();
    i_rx_done = 1'b0;
    i_rx_data = DBIT'($urandom);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [DBIT-1:0] opb, input int maxgap, output int op_cyc);
    for (int k = 0; k < NB; k++) begin
      send_byte(a[k*DBIT +: DBIT]);
      repeat ($urandom_range(maxgap, 0)) step();
    end
    for (int k = 0; k < NB; k++) begin
      send_byte(b[k*DBIT +: DBIT]);
      repeat ($urandom_range(maxgap, 0)) step();
    end
    op_cyc = cyc;
    send_byte(opb);
  endtask

  task automatic wait_idle(input bit junk);
    for (int i = 0; i < 200 && o_busy; i++) begin
      if (junk) begin
        i_rx_done = i[0];
        i_rx_data = DBIT'($urandom);
      end
      step();
    end
    i_rx_done = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [DBIT-1:0] opb, input int op_cyc, input int e0);
    logic [DATA_W-1:0] exp;
    logic [31:0] obs;
    exp = alu_f(opb[OP_W-1:0], a, b);
    check({tag, ".busy"}, o_busy, 0);
    check({tag, ".opa"}, o_alu_datoa, a);
    check({tag, ".opb"}, o_alu_datob, b);
    check({tag, ".opcode"}, o_alu_opcode, opb[OP_W-1:0]);
    check({tag, ".ntx"}, tx_q.size(), NB);
    for (int k = 0; k < NB; k++) begin
      obs = (k < tx_q.size()) ? 32'(tx_q[k]) : 32'hxxxxxxxx;
      check($sformatf("%s.txbyte%0d", tag, k), obs, exp[k*DBIT +: DBIT]);
    end
    check({tag, ".latency"}, first_start_cyc - op_cyc, 2);
    check({tag, ".txhold"}, o_tx_data, exp[(NB-1)*DBIT +: DBIT]);
    check({tag, ".noerr"}, err_cnt - e0, 0);
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [DBIT-1:0] opb, input int maxgap, input bit junk, input string tag);
    int op_cyc;
    int e0;
    tx_q.delete();
    first_start_cyc = -1;
    e0 = err_cnt;
    send_frame(a, b, opb, maxgap, op_cyc);
    wait_idle(junk);
    check_result(tag, a, b, opb, op_cyc, e0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".opa0"}, o_alu_datoa, 0);
    check({tag, ".opb0"}, o_alu_datob, 0);
    check({tag, ".opcode0"}, o_alu_opcode, 0);
    check({tag, ".txdata0"}, o_tx_data, 0);
    check({tag, ".txstart0"}, o_tx_start, 0);
    check({tag, ".busy0"}, o_busy, 0);
    check({tag, ".ferr0"}, o_frame_err, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] a, b, pa, pb;
    logic [DBIT-1:0] opb;
    logic [OP_W-1:0] pop;
    logic [OP_W-1:0] ops[6];
    int acc, e0, op_cyc;
    ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h2a};

    i_reset = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    i_tx_done = 1'b0;
    repeat (3) step();
    check_zero("reset");
    i_reset = 1'b0;
    step();

    // Default example: 0x1234 + 0x5678 = 0x68AC, sent AC then 68.
    run_frame(16'h1234, 16'h5678, 8'h02, 0, 1'b0, "dflt");
    check("dflt.byte0_const", tx_q.size() > 0 ? 32'(tx_q[0]) : 32'hxxxxxxxx, 8'hAC);
    check("dflt.byte1_const", tx_q.size() > 1 ? 32'(tx_q[1]) : 32'hxxxxxxxx, 8'h68);

    for (int i = 0; i < 6; i++) begin
      a = DATA_W'($urandom);
      b = DATA_W'($urandom);
      opb = {2'($urandom), ops[$urandom_range(5, 0)]};
      run_frame(a, b, opb, 3, 1'b0, $sformatf("rand%0d", i));
    end

    run_frame(16'hBEEF, 16'h0F0F, 8'h06, 2, 1'b1, "rxjunk");

    tx_hold = 1'b1;
    run_frame(16'h8001, 16'h7FFF, 8'h02, 1, 1'b0, "txhold");
    tx_hold = 1'b0;
    tx_cd = 0;
    repeat (2) step();

    // Idle with no frame open never times out.
    e0 = err_cnt;
    repeat (1500) step();
    check("idle.noerr", err_cnt - e0, 0);

    // Partial frame abandoned after one byte.
    pa = o_alu_datoa;
    pb = o_alu_datob;
    pop = o_alu_opcode;
    err_cnt = 0;
    send_byte(8'h34);
    acc = cyc;
    repeat (1005) step();
    check("tmo.count", err_cnt, 1);
    check("tmo.cycle", err_cyc - acc, TIMEOUT_CYC);
    check("tmo.opa_kept", o_alu_datoa, pa);
    check("tmo.opb_kept", o_alu_datob, pb);
    check("tmo.op_kept", o_alu_opcode, pop);
    run_frame(16'hA5C3, 16'h1111, 8'h03, 2, 1'b0, "after_tmo");

    // Bytes arriving exactly on the expiry edge are accepted.
    err_cnt = 0;
    tx_q.delete();
    first_start_cyc = -1;
    send_byte(8'h21);
    repeat (TIMEOUT_CYC - 1) step();
    send_byte(8'h43);
    repeat (TIMEOUT_CYC - 1) step();
    send_byte(8'h65);
    send_byte(8'h87);
    op_cyc = cyc;
    send_byte(8'h05);
    wait_idle(1'b0);
    check_result("edge_tmo", 16'h4321, 16'h8765, 8'h05, op_cyc, 0);

    // Reset in the middle of operand B.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check_zero("midreset");
    step();
    run_frame(16'hCAFE, 16'h0102, 8'h04, 1, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
